// File: rtl/ahb_arbiter_slave.sv
// Per-slave round-robin AHB arbiter: grants one master at a time, holds the grant
// across bursts, and tracks the data-phase owner for write-data/response steering.
module ahb_arbiter_slave #(
   parameter int unsigned SLAVE_X_MASTER_NUM = 3,
   parameter int unsigned MAX_HOLD           = 16,
   parameter int unsigned IDX_WIDTH          = $clog2(SLAVE_X_MASTER_NUM)
) (
   input  logic                            hclk,
   input  logic                            hreset,
   input  logic [SLAVE_X_MASTER_NUM-1:0]   hreq,
   input  logic [2*SLAVE_X_MASTER_NUM-1:0] htrans,
   input  logic                            hready,
   output logic [SLAVE_X_MASTER_NUM-1:0]   hgrant,
   output logic [IDX_WIDTH-1:0]            haddr_master,
   output logic [IDX_WIDTH-1:0]            hdata_master,
   output logic                            hdata_valid
);

   localparam int unsigned N = SLAVE_X_MASTER_NUM;

   localparam logic [0:0] ARB_IDLE  = 1'b0;
   localparam logic [0:0] ARB_OWNED = 1'b1;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;

   localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

   logic [0:0]           state;
   logic [7:0]           hold_cnt;
   logic [IDX_WIDTH-1:0] rr_ptr;

   logic [1:0]           owner_trans;
   logic                 owner_req;
   logic [N-1:0]         others;
   logic                 rel_hold;
   logic                 rel_now;
   logic                 accept;
   logic [N-1:0]         cand;
   logic                 pick_found;
   logic [IDX_WIDTH-1:0] pick_idx;
   logic [N-1:0]         pick_onehot;

   always_comb begin
      owner_trans = htrans[{haddr_master, 1'b0} +: 2];
      owner_req   = hreq[haddr_master];
      others      = hreq & ~hgrant;
      // Hold-limit release rejects the owner's NONSEQ beat and excludes it from the pick.
      rel_hold    = (state == ARB_OWNED) && owner_req && (owner_trans == HTRANS_NONSEQ) &&
                    (hold_cnt >= MAX_HOLD_C) && (|others);
      rel_now     = (state == ARB_OWNED) &&
                    (!owner_req || (owner_trans == HTRANS_IDLE) || rel_hold);
      accept      = (state == ARB_OWNED) && owner_req && owner_trans[1] && !rel_hold;
      cand        = rel_hold ? others : hreq;
   end

   always_comb begin
      pick_found  = 1'b0;
      pick_idx    = '0;
      pick_onehot = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         int unsigned idx;
         idx = (int'(rr_ptr) + k) % N;
         if (!pick_found && cand[IDX_WIDTH'(idx)]) begin
            pick_found                    = 1'b1;
            pick_idx                      = IDX_WIDTH'(idx);
            pick_onehot[IDX_WIDTH'(idx)]  = 1'b1;
         end
      end
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state        <= ARB_IDLE;
         hgrant       <= '0;
         haddr_master <= '0;
         hdata_master <= '0;
         hdata_valid  <= 1'b0;
         hold_cnt     <= '0;
         rr_ptr       <= IDX_WIDTH'(N - 1);
      end else if (hready) begin
         hdata_valid <= accept;
         if (accept) begin
            hdata_master <= haddr_master;
         end
         if ((state == ARB_IDLE) || rel_now) begin
            if (pick_found) begin
               state        <= ARB_OWNED;
               hgrant       <= pick_onehot;
               haddr_master <= pick_idx;
               rr_ptr       <= pick_idx;
               hold_cnt     <= '0;
            end else begin
               state  <= ARB_IDLE;
               hgrant <= '0;
            end
         end else if ((owner_trans == HTRANS_NONSEQ) && (hold_cnt != 8'hFF)) begin
            hold_cnt <= hold_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_ahb_arbiter_slave.sv
// Bench for ahb_arbiter_slave: two instances (default hold limit and MAX_HOLD=2) share
// stimulus and are checked every cycle against a transaction-level model.
module tb_ahb_arbiter_slave;

   localparam int N = 3;
   localparam logic [1:0] I = 2'd0, B = 2'd1, NS = 2'd2, S = 2'd3;

   logic       hclk = 1'b0;
   logic       hreset;
   logic       hready;
   logic [2:0] hreq;
   logic [5:0] htrans;

   logic [2:0] g0, g1;
   logic [1:0] a0, a1, d0, d1;
   logic       v0, v1;

   int tests = 0;
   int fails = 0;

   always #5 hclk = ~hclk;

   ahb_arbiter_slave #(.SLAVE_X_MASTER_NUM(3), .MAX_HOLD(16)) u_dut (
      .hclk(hclk), .hreset(hreset), .hreq(hreq), .htrans(htrans), .hready(hready),
      .hgrant(g0), .haddr_master(a0), .hdata_master(d0), .hdata_valid(v0)
   );

   ahb_arbiter_slave #(.SLAVE_X_MASTER_NUM(3), .MAX_HOLD(2)) u_dut_hold2 (
      .hclk(hclk), .hreset(hreset), .hreq(hreq), .htrans(htrans), .hready(hready),
      .hgrant(g1), .haddr_master(a1), .hdata_master(d1), .hdata_valid(v1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model state per instance; owner -1 means the slave is unowned.
   int m_owner[2];
   int m_ptr[2];
   int m_cnt[2];
   int m_dm[2];
   bit m_dv[2];
   int m_hold[2] = '{16, 2};
   bit model_live = 1'b0;

   function automatic int rr_next(input int ptr, input logic [2:0] mask);
      for (int k = 1; k <= N; k++) begin
         int idx = (ptr + k) % N;
         if (mask[idx]) return idx;
      end
      return -1;
   endfunction

   always @(posedge hclk) begin
      int p, o;
      logic [1:0] t;
      logic [2:0] oth;
      bit req, over, accepted;
      for (int i = 0; i < 2; i++) begin
         if (hreset) begin
            m_owner[i] = -1; m_ptr[i] = N - 1; m_cnt[i] = 0; m_dv[i] = 0; m_dm[i] = 0;
         end else if (hready) begin
            if (m_owner[i] < 0) begin
               m_dv[i] = 0;
               p = rr_next(m_ptr[i], hreq);
               if (p >= 0) begin m_owner[i] = p; m_ptr[i] = p; m_cnt[i] = 0; end
            end else begin
               o = m_owner[i];
               t = htrans[2*o +: 2];
               req = hreq[o];
               oth = hreq; oth[o] = 1'b0;
               over = req && (t == NS) && (m_cnt[i] >= m_hold[i]) && (oth != 0);
               accepted = req && (t == NS || t == S) && !over;
               m_dv[i] = accepted;
               if (accepted) m_dm[i] = o;
               if (!req || t == I || over) begin
                  p = rr_next(m_ptr[i], over ? oth : hreq);
                  if (p >= 0) begin m_owner[i] = p; m_ptr[i] = p; m_cnt[i] = 0; end
                  else m_owner[i] = -1;
               end else if (t == NS && m_cnt[i] < 255) begin
                  m_cnt[i] = m_cnt[i] + 1;
               end
            end
         end
      end
      if (hreset) model_live = 1'b1;
   end

   task automatic cmp(input int i, input logic [2:0] g, input logic [1:0] a,
                      input logic [1:0] d, input logic v);
      int exp_g;
      exp_g = (m_owner[i] < 0) ? 0 : (1 << m_owner[i]);
      chk($sformatf("inst%0d hgrant", i), g, exp_g);
      chk($sformatf("inst%0d hdata_valid", i), v, m_dv[i]);
      chk($sformatf("inst%0d hdata_master", i), d, m_dm[i]);
      if (m_owner[i] >= 0) chk($sformatf("inst%0d haddr_master", i), a, m_owner[i]);
   endtask

   always @(negedge hclk) begin
      if (model_live) begin
         cmp(0, g0, a0, d0, v0);
         cmp(1, g1, a1, d1, v1);
      end
   end

   task automatic step(input logic [2:0] rq, input logic [1:0] t0, input logic [1:0] t1,
                       input logic [1:0] t2, input logic rdy = 1'b1);
      hreset = 1'b0;
      hreq   = rq;
      htrans = {t2, t1, t0};
      hready = rdy;
      @(posedge hclk);
      @(negedge hclk);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      hreset = 1'b1; hreq = '0; htrans = '0; hready = 1'b1;
      repeat (2) @(negedge hclk);
      chk("reset hgrant", g0, 0);
      chk("reset hdata_valid", v0, 0);
      chk("reset haddr_master", a0, 0);
      chk("reset hdata_master", d0, 0);

      repeat (5) step(3'b000, I, I, I);
      chk("no req hgrant", g0, 0);
      chk("no req hdata_valid", v0, 0);

      // Round-robin with wrap
      step(3'b110, I, NS, NS);
      chk("first grant m1", g0, 3'b010);
      chk("first grant m1 hold2", g1, 3'b010);
      step(3'b110, I, NS, NS);
      chk("m1 data valid", v0, 1);
      chk("m1 data master", d0, 1);
      step(3'b110, I, I, NS);
      chk("handover to m2", g0, 3'b100);
      chk("haddr m2", a0, 2);
      step(3'b110, I, NS, NS);
      chk("m2 data master", d0, 2);
      step(3'b110, I, NS, I);
      chk("wrap to m1", g0, 3'b010);

      // Owner drops hreq without going IDLE
      step(3'b010, I, NS, I);
      step(3'b000, I, B, I);
      chk("drop hreq hgrant", g0, 0);
      chk("drop hreq hdata_valid", v0, 0);
      step(3'b000, I, I, I);
      chk("drop hreq later hdata_valid", v0, 0);

      // INCR4 by master 0 with master 1 waiting
      step(3'b011, NS, NS, I);
      chk("incr4 grant m0", g0, 3'b001);
      step(3'b011, NS, NS, I);
      chk("incr4 beat1 valid", v0, 1);
      chk("incr4 beat1 dmaster", d0, 0);
      step(3'b011, S, NS, I);
      step(3'b011, S, NS, I);
      step(3'b011, S, NS, I);
      chk("incr4 beat4 grant", g0, 3'b001);
      chk("incr4 beat4 hold2 grant", g1, 3'b001);
      step(3'b011, I, NS, I);
      chk("incr4 handover m1", g0, 3'b010);
      step(3'b000, I, I, I);
      step(3'b000, I, I, I);

      // Same burst with a 3-cycle stall on beat 2
      step(3'b011, NS, NS, I);
      step(3'b011, NS, NS, I);
      for (int k = 0; k < 3; k++) begin
         step(3'b011, S, NS, I, 1'b0);
         chk("stall hgrant", g0, 3'b001);
         chk("stall haddr", a0, 0);
         chk("stall hdata_master", d0, 0);
         chk("stall hdata_valid", v0, 1);
      end
      step(3'b011, S, NS, I);
      step(3'b011, S, NS, I);
      step(3'b011, S, NS, I);
      chk("stall burst end grant", g0, 3'b001);
      step(3'b011, I, NS, I);
      chk("stall burst handover", g0, 3'b010);

      // Reset mid-burst
      step(3'b010, I, NS, I);
      step(3'b010, I, S, I);
      hreset = 1'b1;
      @(posedge hclk);
      @(negedge hclk);
      chk("midburst reset hgrant", g0, 0);
      chk("midburst reset hgrant hold2", g1, 0);
      chk("midburst reset hdata_valid", v0, 0);
      chk("midburst reset haddr", a0, 0);
      chk("midburst reset hdata_master", d0, 0);

      // Hold limit: master 0 streams NONSEQ, master 2 waits
      step(3'b101, NS, I, NS);
      chk("hold grant m0", g1, 3'b001);
      step(3'b101, NS, I, NS);
      step(3'b101, NS, I, NS);
      chk("hold second accepted", v1, 1);
      step(3'b101, NS, I, NS);
      chk("hold2 handover m2", g1, 3'b100);
      chk("hold2 rejected beat valid", v1, 0);
      chk("hold2 rejected dmaster", d1, 0);
      chk("hold16 keeps m0", g0, 3'b001);
      chk("hold16 beat valid", v0, 1);
      step(3'b101, NS, I, NS);
      chk("hold2 m2 data master", d1, 2);
      step(3'b101, NS, I, I);
      chk("hold2 back to m0", g1, 3'b001);
      step(3'b000, I, I, I);
      step(3'b000, I, I, I);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
